// File: rtl/ps2_rx_fifo.sv
// PS/2 receiver: synchronises and glitch-filters the PS/2 clock, assembles
// 11-bit frames (start, 8 data LSB first, odd parity, stop) and pushes good
// scan codes into a small FIFO with sticky error reporting.
module ps2_rx_fifo #(
    parameter int DEPTH_LOG2  = 3,
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  ps2_clk,
    input  logic                  ps2_data,
    input  logic                  nextdata_n,
    output logic [7:0]            data,
    output logic                  ready,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic                  parity_err,
    output logic                  frame_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [4:0] FILT_MAX = 5'(FILTER_LEN - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic       clk_s1_reg, clk_s2_reg, data_s1_reg, data_s2_reg;
    logic       filt_reg, filt_prev_reg;
    logic [4:0] filt_cnt_reg;
    logic       strobe, bit_in;

    state_t            state_reg, state_next;
    logic [2:0]        bit_cnt_reg, bit_cnt_next;
    logic [7:0]        shift_reg, shift_next;
    logic              par_reg, par_next;
    logic [TO_W-1:0]   to_cnt_reg, to_cnt_next;
    logic              wr_req, perr_set, ferr_set;
    logic              wr_en_reg;
    logic [7:0]        wr_data_reg;

    logic [7:0]          mem [DEPTH];
    logic [DEPTH_LOG2:0] wptr_reg, rptr_reg, wptr_next, rptr_next;
    logic [DEPTH_LOG2:0] level_reg;
    logic                ready_reg, ovf_reg, perr_reg, ferr_reg;
    logic                full, rd_do, wr_do;

    // Two-flop synchronisers; idle-high lines reset to 1
    always_ff @(posedge clk) begin
        if (clr) begin
            clk_s1_reg  <= 1'b1;
            clk_s2_reg  <= 1'b1;
            data_s1_reg <= 1'b1;
            data_s2_reg <= 1'b1;
        end else begin
            clk_s1_reg  <= ps2_clk;
            clk_s2_reg  <= clk_s1_reg;
            data_s1_reg <= ps2_data;
            data_s2_reg <= data_s1_reg;
        end
    end

    // Glitch filter: follow the synchronised clock only after a full run of differing samples
    always_ff @(posedge clk) begin
        if (clr) begin
            filt_reg      <= 1'b1;
            filt_prev_reg <= 1'b1;
            filt_cnt_reg  <= '0;
        end else begin
            filt_prev_reg <= filt_reg;
            if (clk_s2_reg != filt_reg) begin
                if (filt_cnt_reg == FILT_MAX) begin
                    filt_reg     <= clk_s2_reg;
                    filt_cnt_reg <= '0;
                end else begin
                    filt_cnt_reg <= filt_cnt_reg + 5'd1;
                end
            end else begin
                filt_cnt_reg <= '0;
            end
        end
    end

    assign strobe = filt_prev_reg & ~filt_reg;
    assign bit_in = data_s2_reg;

    // Frame FSM next-state, bit capture and timeout
    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        par_next     = par_reg;
        to_cnt_next  = (state_reg == IDLE || strobe) ? '0 : to_cnt_reg + TO_W'(1);
        wr_req       = 1'b0;
        perr_set     = 1'b0;
        ferr_set     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (strobe && !bit_in) begin
                    state_next   = DATA;
                    bit_cnt_next = 3'd0;
                end
            end
            DATA: begin
                if (strobe) begin
                    shift_next[bit_cnt_reg] = bit_in;
                    if (bit_cnt_reg == 3'd7) begin
                        state_next = PARITY;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (strobe) begin
                    par_next   = bit_in;
                    state_next = STOP;
                end
            end
            STOP: begin
                if (strobe) begin
                    state_next = IDLE;
                    perr_set   = ~(^{shift_reg, par_reg});
                    ferr_set   = ~bit_in;
                    wr_req     = bit_in & (^{shift_reg, par_reg});
                end
            end
            default: state_next = IDLE;
        endcase
        // A stalled frame is abandoned once the gap reaches the timeout
        if (state_reg != IDLE && !strobe && to_cnt_reg == TO_LAST) begin
            state_next  = IDLE;
            to_cnt_next = '0;
            ferr_set    = 1'b1;
        end
    end

    // Frame FSM registers and the one-cycle-delayed write request
    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            par_reg     <= 1'b0;
            to_cnt_reg  <= '0;
            wr_en_reg   <= 1'b0;
            wr_data_reg <= '0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            par_reg     <= par_next;
            to_cnt_reg  <= to_cnt_next;
            wr_en_reg   <= wr_req;
            wr_data_reg <= shift_reg;
        end
    end

    assign full  = (wptr_reg[DEPTH_LOG2] != rptr_reg[DEPTH_LOG2]) &&
                   (wptr_reg[DEPTH_LOG2-1:0] == rptr_reg[DEPTH_LOG2-1:0]);
    assign rd_do = ready_reg & ~nextdata_n;
    assign wr_do = wr_en_reg & (~full | rd_do);

    // Pointer next values; a write into a full FIFO only proceeds alongside a pop
    always_comb begin
        wptr_next = wptr_reg + (wr_do ? 1'b1 : 1'b0);
        rptr_next = rptr_reg + (rd_do ? 1'b1 : 1'b0);
    end

    // FIFO pointers, occupancy and sticky flags
    always_ff @(posedge clk) begin
        if (clr) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            level_reg <= '0;
            ready_reg <= 1'b0;
            ovf_reg   <= 1'b0;
            perr_reg  <= 1'b0;
            ferr_reg  <= 1'b0;
        end else begin
            wptr_reg  <= wptr_next;
            rptr_reg  <= rptr_next;
            level_reg <= wptr_next - rptr_next;
            ready_reg <= (wptr_next != rptr_next);
            ovf_reg   <= ovf_reg | (wr_en_reg & full & ~rd_do);
            perr_reg  <= perr_reg | perr_set;
            ferr_reg  <= ferr_reg | ferr_set;
        end
    end

    // Scan code storage, contents survive reset
    always_ff @(posedge clk) begin
        if (wr_do) begin
            mem[wptr_reg[DEPTH_LOG2-1:0]] <= wr_data_reg;
        end
    end

    assign data       = mem[rptr_reg[DEPTH_LOG2-1:0]];
    assign ready      = ready_reg;
    assign level      = level_reg;
    assign overflow   = ovf_reg;
    assign parity_err = perr_reg;
    assign frame_err  = ferr_reg;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: bit-banged PS/2 frames, scoreboard queue of
// expected scan codes, table of single-frame vectors plus corner sequences.
module tb_ps2_rx_fifo;

    localparam int HALF = 12;
    localparam int TIMEOUT_CYC = 5000;

    logic       clk, clr, ps2_clk, ps2_data, nextdata_n;
    logic [7:0] data;
    logic       ready, overflow, parity_err, frame_err;
    logic [3:0] level;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] q[$];
    logic m_ovf, m_perr, m_ferr;

    typedef struct {
        logic [7:0] code;
        logic       par_flip;
        logic       stop;
        int         exp_level;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;
    vec_t vecs[7];

    ps2_rx_fifo #(.DEPTH_LOG2(3), .FILTER_LEN(4), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .clr(clr), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .nextdata_n(nextdata_n), .data(data), .ready(ready), .level(level),
        .overflow(overflow), .parity_err(parity_err), .frame_err(frame_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end else begin
            $display("ok   %s value=%0h", name, act);
        end
    endtask

    task automatic do_clr();
        clr = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; nextdata_n = 1'b1;
        tick();
        clr = 1'b0;
        q.delete();
        m_ovf = 1'b0; m_perr = 1'b0; m_ferr = 1'b0;
        tick();
    endtask

    task automatic check_flags(input string tag);
        check({tag, " level"}, int'(level), q.size());
        check({tag, " ready"}, int'(ready), (q.size() != 0) ? 1 : 0);
        check({tag, " overflow"}, int'(overflow), int'(m_ovf));
        check({tag, " parity_err"}, int'(parity_err), int'(m_perr));
        check({tag, " frame_err"}, int'(frame_err), int'(m_ferr));
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] exp;
        check({tag, " ready_before_pop"}, int'(ready), 1);
        if (q.size() > 0) begin
            exp = q.pop_front();
            check({tag, " data"}, int'(data), int'(exp));
        end
        nextdata_n = 1'b0;
        tick();
        nextdata_n = 1'b1;
    endtask

    // Sends the first nbits of a frame; optional clock glitch in one bit's high
    // phase; optional pop timed to land on the same edge as the FIFO write.
    task automatic send_frame(input logic [7:0] code, input logic par_flip,
                              input logic stop_bit, input int nbits,
                              input int glitch_bit, input logic pop_at_write);
        logic [10:0] bits;
        logic [3:0]  lv0;
        int          lat;
        bit          good, expect_lat;
        bits = {stop_bit, (~^code) ^ par_flip, code, 1'b0};
        good = !par_flip && stop_bit && nbits == 11;
        expect_lat = good && !pop_at_write && q.size() < 8;
        lat = 0;
        for (int b = 0; b < nbits; b++) begin
            ps2_data = bits[b];
            if (b == glitch_bit) begin
                repeat (6) tick();
                ps2_clk = 1'b0;
                repeat (3) tick();
                ps2_clk = 1'b1;
                repeat (HALF - 9) tick();
            end else begin
                repeat (HALF) tick();
            end
            ps2_clk = 1'b0;
            lv0 = level;
            for (int i = 1; i <= HALF; i++) begin
                tick();
                if (nextdata_n == 1'b0) nextdata_n = 1'b1;
                if (b == 10 && lat == 0 && level != lv0) lat = i;
                if (b == 10 && pop_at_write && i == 7) begin
                    check("coincident_pop ready", int'(ready), 1);
                    check("coincident_pop data", int'(data), int'(q.pop_front()));
                    nextdata_n = 1'b0;
                end
            end
            ps2_clk = 1'b1;
        end
        if (nbits == 11) begin
            if (expect_lat) check("wr_latency", lat, 8);
            if (good) begin
                if (pop_at_write || q.size() < 8) q.push_back(code);
                else m_ovf = 1'b1;
            end
            if (par_flip) m_perr = 1'b1;
            if (!stop_bit) m_ferr = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (HALF) tick();
    endtask

    initial begin
        #5ms;
        n_fail++;
        $display("FAIL watchdog expired");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        vecs[0] = '{8'h1C, 1'b0, 1'b1, 1, 1'b0, 1'b0};
        vecs[1] = '{8'h1C, 1'b1, 1'b1, 0, 1'b1, 1'b0};
        vecs[2] = '{8'h32, 1'b0, 1'b1, 1, 1'b0, 1'b0};
        vecs[3] = '{8'h5A, 1'b0, 1'b0, 0, 1'b0, 1'b1};
        vecs[4] = '{8'h77, 1'b1, 1'b0, 0, 1'b1, 1'b1};
        vecs[5] = '{8'h00, 1'b0, 1'b1, 1, 1'b0, 1'b0};
        vecs[6] = '{8'hFF, 1'b0, 1'b1, 1, 1'b0, 1'b0};

        do_clr();
        check_flags("reset");

        // Popping an empty FIFO changes nothing
        nextdata_n = 1'b0;
        repeat (3) tick();
        nextdata_n = 1'b1;
        check_flags("pop_empty");

        // Single-frame vectors, each from a clean reset
        for (int v = 0; v < 7; v++) begin
            do_clr();
            send_frame(vecs[v].code, vecs[v].par_flip, vecs[v].stop, 11, -1, 1'b0);
            check($sformatf("vec%0d level", v), int'(level), vecs[v].exp_level);
            check($sformatf("vec%0d parity_err", v), int'(parity_err), int'(vecs[v].exp_perr));
            check($sformatf("vec%0d frame_err", v), int'(frame_err), int'(vecs[v].exp_ferr));
            if (vecs[v].exp_level == 1) pop_check($sformatf("vec%0d", v));
            check($sformatf("vec%0d ready_after", v), int'(ready), 0);
            check($sformatf("vec%0d level_after", v), int'(level), 0);
        end

        // Bad parity followed by a good frame without reset
        do_clr();
        send_frame(8'h1C, 1'b1, 1'b1, 11, -1, 1'b0);
        check_flags("bad_par");
        send_frame(8'h32, 1'b0, 1'b1, 11, -1, 1'b0);
        check_flags("after_bad_par");
        pop_check("after_bad_par");

        // Overflow: nine frames into eight slots
        do_clr();
        for (int k = 1; k <= 9; k++) send_frame(8'(k), 1'b0, 1'b1, 11, -1, 1'b0);
        check_flags("overflow");
        for (int k = 0; k < 8; k++) pop_check($sformatf("ovf_pop%0d", k));
        check_flags("ovf_drained");

        // Full FIFO, write coinciding with a pop
        do_clr();
        for (int k = 0; k < 8; k++) send_frame(8'h40 + 8'(k), 1'b0, 1'b1, 11, -1, 1'b0);
        send_frame(8'hAA, 1'b0, 1'b1, 11, -1, 1'b1);
        check_flags("full_pop_write");
        for (int k = 0; k < 8; k++) pop_check($sformatf("fpw_pop%0d", k));
        check_flags("fpw_drained");

        // Short low glitch inside a frame
        do_clr();
        send_frame(8'hF0, 1'b0, 1'b1, 11, 4, 1'b0);
        check_flags("glitch");
        pop_check("glitch");

        // Timeout abandon of a partial frame
        do_clr();
        send_frame(8'h00, 1'b0, 1'b1, 4, -1, 1'b0);
        repeat (TIMEOUT_CYC + 50) tick();
        m_ferr = 1'b1;
        check_flags("timeout");
        send_frame(8'hE0, 1'b0, 1'b1, 11, -1, 1'b0);
        check_flags("after_timeout");
        pop_check("after_timeout");

        // Reset in the middle of a frame
        do_clr();
        send_frame(8'hA5, 1'b0, 1'b1, 5, -1, 1'b0);
        do_clr();
        check_flags("mid_clr");
        send_frame(8'h3C, 1'b0, 1'b1, 11, -1, 1'b0);
        check_flags("after_mid_clr");
        pop_check("after_mid_clr");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_rx_fifo.md
PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 Parameter DEPTH_LOG2, default 3, FIFO depth = 2**DEPTH_LOG2 scan codes.
REQ-002 Parameter FILTER_LEN, default 4, consecutive equal synchronised samples needed to accept a ps2_clk level change (1..16).
REQ-003 Parameter TIMEOUT_CYC, default 5000, clk cycles without a sample strobe before an open frame is abandoned.
REQ-004 clk  input  1  system clock; all state on rising edge; single clock domain.
REQ-005 clr  input  1  reset, synchronous, active-high.
REQ-006 ps2_clk  input  1  asynchronous PS/2 clock line.
REQ-007 ps2_data  input  1  asynchronous PS/2 data line.
REQ-008 nextdata_n  input  1  active-low pop request, honoured only while ready=1.
REQ-009 data  output  8  scan code at FIFO head, combinational from storage.
REQ-010 ready  output  1  FIFO non-empty, registered.
REQ-011 level  output  DEPTH_LOG2+1  current FIFO occupancy, 0..DEPTH.
REQ-012 overflow  output  1  sticky: a valid frame was dropped because FIFO was full.
REQ-013 parity_err  output  1  sticky: a frame failed odd parity.
REQ-014 frame_err  output  1  sticky: bad stop bit or timeout abandon.

Function
REQ-015 ps2_clk and ps2_data each pass through a 2-flop synchroniser before any use.
REQ-016 Filtered clock changes level only after FILTER_LEN consecutive synchronised samples differ from it; shorter glitches are ignored.
REQ-017 Sample strobe = one-cycle pulse on each 1->0 transition of the filtered clock; data bit sampled = synchronised ps2_data that cycle.
REQ-018 Frame FSM states IDLE, DATA, PARITY, STOP; IDLE on reset.
REQ-019 IDLE: strobe with bit=0 -> DATA, bit counter=0; strobe with bit=1 ignored, stay IDLE.
REQ-020 DATA: each strobe stores bit at position counter (LSB first); after 8th bit -> PARITY.
REQ-021 PARITY: strobe stores parity bit -> STOP.
REQ-022 STOP: on strobe, frame good iff stop bit=1 and XOR of 8 data bits and parity bit =1; -> IDLE in all cases.
REQ-023 Bad parity sets parity_err; stop bit=0 sets frame_err; both may set together; bad frames never written.
REQ-024 Timeout counter clears on every strobe and in IDLE; in any other state reaching TIMEOUT_CYC forces IDLE and sets frame_err.
REQ-025 Good frame written in the cycle after the STOP strobe; ready and level reflect it one further clock later (ready rises 2 clk after stop-bit strobe).
REQ-026 Write pointer, read pointer DEPTH_LOG2+1 bits wide; wrap modulo 2*DEPTH; full = MSBs differ and low bits equal; empty = pointers equal.
REQ-027 Pop when ready=1 and nextdata_n=0: read pointer +1 per clk with nextdata_n low (level-sensitive, one entry per cycle).
REQ-028 Pop while empty: no pointer change, no flag.
REQ-029 Write while full with no simultaneous pop: data dropped, pointers unchanged, overflow set.
REQ-030 Write while full with simultaneous pop: both performed, level stays DEPTH, overflow unchanged.
REQ-031 Simultaneous write and pop at any other level: both performed, level unchanged.
REQ-032 level = write pointer - read pointer, registered; ready = (level != 0) consistent with same cycle.
REQ-033 data = storage[read pointer low bits]; value unspecified while ready=0.
REQ-034 Sticky flags clear only via clr.

Reset
REQ-035 clr=1 at a rising edge: FSM IDLE, bit and timeout counters 0, pointers 0, level 0, ready 0, overflow/parity_err/frame_err 0, synchronisers and filtered clock 1.
REQ-036 clr asserted mid-frame discards the partial frame; no write, no flag, on the following cycle.
REQ-037 Storage contents are not reset.

Verification
REQ-038 Frame 0x1C, parity 0, stop 1 -> ready=1, data=0x1C, level=1; pulse nextdata_n 1 clk -> ready=0, level=0.
REQ-039 Frame 0x1C with parity 1 -> no write, parity_err=1, ready stays 0; following good 0x32 -> data=0x32.
REQ-040 DEPTH_LOG2=3: 9 good frames 0x01..0x09, no pops -> level=8, overflow=1; pops yield 0x01..0x08, then ready=0.
REQ-041 ps2_clk low glitch of FILTER_LEN-1 cycles inside a frame -> no extra bit; frame 0xF0 received intact.
REQ-042 Start bit plus 3 data bits, then clock idle TIMEOUT_CYC cycles -> frame_err=1, FSM IDLE; next good 0xE0 received.
REQ-043 Full FIFO (8 entries), good frame write coincides with pop -> level=8, overflow=0, new code last out.
